// File: rtl/parity_generator.sv
// Word and frame parity: parity_out is combinational; parity_q, frame_parity and frame_count appear one cycle after the qualifying edge.
// No backpressure: every in_valid word is accepted, and acc/cnt clear after frame_last so back-to-back frames lose no words.
module parity_generator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic             parity_out,
  input  logic             odd_sel,
  input  logic             in_valid,
  input  logic             frame_last,
  output logic             parity_q,
  output logic             parity_valid,
  output logic             frame_parity,
  output logic             frame_valid,
  output logic [CNT_W-1:0] frame_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             word_par;
  logic             acc;
  logic             acc_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign word_par   = ^in;
  assign parity_out = word_par;

  always_comb begin
    acc_next = acc ^ word_par;
    cnt_next = cnt;
    // Saturate instead of wrapping so an oversized frame never reports a short count.
    if (cnt != CNT_MAX) begin
      cnt_next = cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q     <= 1'b0;
      parity_valid <= 1'b0;
      frame_parity <= 1'b0;
      frame_valid  <= 1'b0;
      frame_count  <= '0;
      acc          <= 1'b0;
      cnt          <= '0;
    end else begin
      parity_valid <= in_valid;
      frame_valid  <= in_valid & frame_last;
      if (in_valid) begin
        parity_q <= word_par ^ odd_sel;
        if (frame_last) begin
          frame_parity <= acc_next ^ odd_sel;
          frame_count  <= cnt_next;
          acc          <= 1'b0;
          cnt          <= '0;
        end else begin
          acc <= acc_next;
          cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_parity_generator.sv
// Scoreboard bench for parity_generator: a default instance plus a CNT_W=4 instance for saturation.
module tb_parity_generator;

  typedef struct packed {
    logic        par;
    logic [15:0] cnt;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in;
  logic        odd_sel, in_valid, frame_last;
  logic        parity_out, parity_q, parity_valid, frame_parity, frame_valid;
  logic [15:0] frame_count;

  logic        s_valid, s_last;
  logic        s_parity_out, s_parity_q, s_parity_valid, s_frame_parity, s_frame_valid;
  logic [3:0]  s_frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic        m_acc;
  logic [15:0] m_cnt;
  logic        wq[$];
  frame_t      fq[$];

  always #5 clk = ~clk;

  parity_generator #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .parity_out(parity_out), .odd_sel(odd_sel),
    .in_valid(in_valid), .frame_last(frame_last), .parity_q(parity_q),
    .parity_valid(parity_valid), .frame_parity(frame_parity),
    .frame_valid(frame_valid), .frame_count(frame_count)
  );

  parity_generator #(.WIDTH(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in(in), .parity_out(s_parity_out), .odd_sel(odd_sel),
    .in_valid(s_valid), .frame_last(s_last), .parity_q(s_parity_q),
    .parity_valid(s_parity_valid), .frame_parity(s_frame_parity),
    .frame_valid(s_frame_valid), .frame_count(s_frame_count)
  );

  // Drive one cycle on the falling edge, push expectations, then settle 1 unit past the rising edge.
  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic o);
    @(negedge clk);
    in = d; in_valid = v; frame_last = l; odd_sel = o;
    if (v) begin
      wq.push_back((^d) ^ o);
      m_acc = m_acc ^ (^d);
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (l) begin
        fq.push_back('{par: m_acc ^ o, cnt: m_cnt});
        m_acc = 1'b0;
        m_cnt = 16'd0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({parity_q, parity_valid, frame_parity, frame_valid, frame_count} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got q=%b pv=%b fp=%b fv=%b fc=%0d, want all 0",
               parity_q, parity_valid, frame_parity, frame_valid, frame_count);
    end
    in = 8'h07;
    #1;
    n_checks++;
    if (parity_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_parity_out: got %b want 1", parity_out);
    end
    @(negedge clk);
    in = 8'h00;
    rst_n = 1'b1;
  endtask

  task automatic test_comb();
    logic [7:0] pat [14];
    logic       exp [14];
    pat = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h02, 8'h04, 8'h08,
            8'h10, 8'h20, 8'h40, 8'h80, 8'h3C, 8'hC3};
    exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      in = pat[i];
      odd_sel = 1'(i % 2);
      #10;
      n_checks++;
      if (parity_out !== exp[i]) begin
        n_fail++;
        $display("FAIL comb_%02h: got %b want %b", pat[i], parity_out, exp[i]);
      end
    end
    odd_sel = 1'b0;
  endtask

  task automatic test_word();
    logic e;
    for (int o = 0; o < 2; o++) begin
      drive(1'b1, 8'h07, 1'b0, 1'(o));
      e = wq.pop_front();
      n_checks++;
      if (parity_valid !== 1'b1 || parity_q !== e) begin
        n_fail++;
        $display("FAIL word_odd%0d: got pv=%b q=%b want pv=1 q=%b", o, parity_valid, parity_q, e);
      end
      drive(1'b0, 8'hFF, 1'b0, 1'(1 - o));
      n_checks++;
      if (parity_valid !== 1'b0 || parity_q !== e) begin
        n_fail++;
        $display("FAIL word_hold%0d: got pv=%b q=%b want pv=0 q=%b", o, parity_valid, parity_q, e);
      end
    end
    // The partial frame of 07 words must be discarded; close it out through the model.
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    void'(wq.pop_front());
    void'(fq.pop_front());
  endtask

  task automatic test_frame();
    frame_t e;
    logic   w;
    logic [7:0] words [3];
    words = '{8'h01, 8'h03, 8'h80};
    for (int o = 0; o < 2; o++) begin
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, words[i], 1'(i == 2), 1'(o));
        w = wq.pop_front();
        n_checks++;
        if (parity_q !== w || frame_valid !== 1'(i == 2)) begin
          n_fail++;
          $display("FAIL frame%0d_word%0d: got q=%b fv=%b want q=%b fv=%b",
                   o, i, parity_q, frame_valid, w, (i == 2));
        end
      end
      e = fq.pop_front();
      n_checks++;
      if (frame_parity !== e.par || frame_count !== e.cnt || e.par !== 1'(o) || e.cnt !== 16'd3) begin
        n_fail++;
        $display("FAIL frame_result%0d: got fp=%b fc=%0d want fp=%b fc=%0d",
                 o, frame_parity, frame_count, e.par, e.cnt);
      end
      drive(1'b0, 8'h00, 1'b1, 1'(1 - o));
      n_checks++;
      if (frame_valid !== 1'b0 || frame_parity !== e.par || frame_count !== e.cnt) begin
        n_fail++;
        $display("FAIL frame_hold%0d: got fv=%b fp=%b fc=%0d want fv=0 fp=%b fc=%0d",
                 o, frame_valid, frame_parity, frame_count, e.par, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t e;
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b0, 8'h7F, 1'b1, 1'b0);
    drive(1'b1, 8'h02, 1'b1, 1'b0);
    e = fq.pop_front();
    n_checks++;
    if (frame_valid !== 1'b1 || frame_parity !== e.par || frame_count !== e.cnt || e.cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_first: got fv=%b fp=%b fc=%0d want fv=1 fp=%b fc=%0d",
               frame_valid, frame_parity, frame_count, e.par, e.cnt);
    end
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    e = fq.pop_front();
    n_checks++;
    if (frame_valid !== 1'b1 || frame_parity !== e.par || frame_count !== e.cnt || e.cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL b2b_second: got fv=%b fp=%b fc=%0d want fv=1 fp=%b fc=%0d",
               frame_valid, frame_parity, frame_count, e.par, e.cnt);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_pulse_end: got fv=%b want 0", frame_valid);
    end
    wq.delete();
  endtask

  task automatic test_mid_reset();
    frame_t e;
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({parity_q, parity_valid, frame_parity, frame_valid, frame_count} !== 20'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got q=%b pv=%b fp=%b fv=%b fc=%0d, want all 0",
               parity_q, parity_valid, frame_parity, frame_valid, frame_count);
    end
    m_acc = 1'b0;
    m_cnt = 16'd0;
    wq.delete();
    fq.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 8'h01, 1'b1, 1'b0);
    e = fq.pop_front();
    n_checks++;
    if (frame_valid !== 1'b1 || frame_parity !== e.par || frame_count !== e.cnt || e.cnt !== 16'd1 || e.par !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_frame: got fv=%b fp=%b fc=%0d want fv=1 fp=%b fc=%0d",
               frame_valid, frame_parity, frame_count, e.par, e.cnt);
    end
    wq.delete();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    int sc;
    sc = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      in = 8'(i);
      s_valid = 1'b1;
      s_last = 1'(i == 20);
      sc = (sc == 15) ? 15 : sc + 1;
      @(posedge clk);
      #1;
      if (i < 20) begin
        n_checks += (i == 19) ? 1 : 0;
        if (i == 19 && s_frame_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_early_pulse: got fv=%b want 0", s_frame_valid);
        end
      end
    end
    n_checks++;
    if (s_frame_valid !== 1'b1 || s_frame_count !== 4'(sc)) begin
      n_fail++;
      $display("FAIL sat_count: got fv=%b fc=%0d want fv=1 fc=%0d", s_frame_valid, s_frame_count, sc);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in = 8'h00; odd_sel = 1'b0; in_valid = 1'b0; frame_last = 1'b0;
    s_valid = 1'b0; s_last = 1'b0;
    m_acc = 1'b0;
    m_cnt = 16'd0;
    test_reset();
    test_comb();
    test_word();
    test_frame();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_generator.md
PARITY_GENERATOR -- requirements
Module: parity_generator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits (legal range 2 to 64).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the frame word counter.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port in  input  WIDTH  data word.
REQ-006 The block SHALL have port parity_out  output  1  combinational even parity of in.
REQ-007 The block SHALL have port odd_sel  input  1  selects odd parity (1) or even parity (0) for the registered outputs.
REQ-008 The block SHALL have port in_valid  input  1  qualifies in for the registered paths.
REQ-009 The block SHALL have port frame_last  input  1  marks the final valid word of a frame; ignored when in_valid=0.
REQ-010 The block SHALL have port parity_q  output  1  registered per-word parity.
REQ-011 The block SHALL have port parity_valid  output  1  parity_q qualifier.
REQ-012 The block SHALL have port frame_parity  output  1  parity over all words of the completed frame.
REQ-013 The block SHALL have port frame_valid  output  1  single-cycle frame completion strobe.
REQ-014 The block SHALL have port frame_count  output  CNT_W  number of words in the completed frame.

Function
REQ-015 parity_out SHALL equal the XOR reduction of in, with zero latency, and SHALL be independent of clk, rst_n, odd_sel and in_valid.
REQ-016 On a rising edge with in_valid=1, parity_q SHALL load (XOR of in) XOR odd_sel, and parity_valid SHALL be 1 in the following cycle.
REQ-017 On a rising edge with in_valid=0, parity_valid SHALL be 0 and parity_q SHALL hold its value.
REQ-018 The internal accumulator acc and word counter cnt SHALL update on every in_valid=1 edge: acc_next = acc XOR (XOR of in); cnt_next = cnt+1, saturating at all-ones.
REQ-019 On an in_valid=1, frame_last=1 edge, frame_parity SHALL load acc_next XOR odd_sel (odd_sel sampled on that edge), frame_count SHALL load cnt_next, and frame_valid SHALL be 1 for exactly the next cycle.
REQ-020 After a frame_last edge, acc and cnt SHALL clear to 0 so the next valid word starts a new frame.
REQ-021 A single-word frame (frame_last on the first valid word) SHALL produce frame_count=1 and frame_parity equal to that word's parity XOR odd_sel.
REQ-022 frame_parity and frame_count SHALL hold their values between frame_valid strobes.
REQ-023 Back-to-back frames, with frame_last on consecutive valid cycles, SHALL each produce their own frame_valid pulse with no lost words.
REQ-024 Cycles with in_valid=0 inside a frame SHALL leave acc and cnt unchanged.

Reset
REQ-025 rst_n=0 SHALL immediately, without waiting for a clock edge, force parity_q=0, parity_valid=0, frame_parity=0, frame_valid=0, frame_count=0, acc=0, cnt=0.
REQ-026 Assertion of rst_n in the middle of a frame SHALL discard the partial frame, and the first valid word after release SHALL start a new frame.
REQ-027 parity_out SHALL remain functional during reset.
REQ-028 Release of rst_n SHALL be synchronous-safe: the first state update SHALL occur on the first rising edge after release.

Verification
REQ-029 Combinational sweep: in = 00, FF, 55, AA, 01, 02, 04, 08, 10, 20, 40, 80, 3C, C3 each held 10 time units -> parity_out = 0,0,0,0,1,1,1,1,1,1,1,1,0,0.
REQ-030 Registered word: odd_sel=0, in=8'h07, in_valid=1 for one cycle -> next cycle parity_q=1, parity_valid=1; following cycle parity_valid=0. Repeat with odd_sel=1 -> parity_q=0.
REQ-031 Frame: words 01, 03, 80 with frame_last on 80, odd_sel=0 -> frame_valid pulse, frame_parity=0, frame_count=3; repeat with odd_sel=1 -> frame_parity=1.
REQ-032 Gaps and back-to-back frames: frame {01, idle, 02 last} then immediately {FF last} -> frame_count=2, frame_parity=0, then frame_count=1, frame_parity=0, two separate pulses.
REQ-033 Mid-frame reset: send 01, 01, pulse rst_n low asynchronously, then send 01 last -> all outputs 0 during reset; afterwards frame_count=1, frame_parity=1.
REQ-034 Saturation: with CNT_W=4, send 20 valid words, then last -> frame_count=15.
